apb_reg_slave: RTL and testbench

//  APB completer: register bank plus down-count timer; it is the responder end of ral_if (PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA).

---
 rtl/apb_reg_slave.sv | 151 +++++++++++++++
 tb/tb_apb_reg_slave.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_reg_slave.sv
// Zero-wait-state APB completer: register bank with an optional down-count timer.
// Define APB_REG_TIMER_EN to build the timer, COUNT, INTSTAT and irq; otherwise those read 0.
module apb_reg_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] LOAD_RST    = 32'h0000_FFFF,
    parameter logic [31:0] SCRATCH_RST = 32'h0000_0000,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        irq,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } phase_t;

    phase_t state;

    logic [31:0] offset;
    logic        in_win;
    logic [2:0]  reg_idx;
    logic        wr_commit;
    logic        rd_capture;
    logic        wr_ctrl;
    logic        wr_load;
    logic        wr_scratch;

    logic [1:0]  ctrl_reg;
    logic [31:0] load_reg;
    logic [31:0] scratch_reg;
    logic [31:0] count_val;
    logic        wrap_val;
    logic [31:0] rd_mux;

    // Handshake: a write lands only when PSEL&PENABLE is still held in the cycle
    // after the FSM reached ACCESS; a read samples the bank at the end of SETUP.
    assign offset     = PADDR - BASE_ADDR;
    assign in_win     = (offset < 32'd32);
    assign reg_idx    = offset[4:2];
    assign wr_commit  = (state == ACCESS) && PSEL && PENABLE && PWRITE;
    assign rd_capture = PSEL && !PENABLE && !PWRITE;
    assign wr_ctrl    = wr_commit && in_win && (reg_idx == 3'd0);
    assign wr_load    = wr_commit && in_win && (reg_idx == 3'd2);
    assign wr_scratch = wr_commit && in_win && (reg_idx == 3'd5);
    assign fsm_state  = state;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    state <= (PSEL && !PENABLE) ? SETUP : IDLE;
                SETUP: begin
                    if (PSEL && PENABLE)
                        state <= ACCESS;
                    else if (PSEL)
                        state <= SETUP;
                    else
                        state <= IDLE;
                end
                ACCESS:  state <= (PSEL && !PENABLE) ? SETUP : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl_reg    <= 2'b00;
            load_reg    <= LOAD_RST;
            scratch_reg <= SCRATCH_RST;
        end else begin
            if (wr_ctrl)
                ctrl_reg <= PWDATA[1:0];
            if (wr_load)
                load_reg <= PWDATA;
            if (wr_scratch)
                scratch_reg <= PWDATA;
        end
    end

`ifdef APB_REG_TIMER_EN
    logic [31:0] count_reg;
    logic        wrap_reg;
    logic        wr_intstat;
    logic        wrap_set;

    assign wr_intstat = wr_commit && in_win && (reg_idx == 3'd4);
    assign wrap_set   = ctrl_reg[0] && (count_reg == 32'd0);

    // Enabling reloads immediately; a wrap on the same edge as a W1C keeps WRAP set.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            count_reg <= 32'd0;
            wrap_reg  <= 1'b0;
        end else begin
            if (wr_ctrl && PWDATA[0] && !ctrl_reg[0])
                count_reg <= load_reg;
            else if (ctrl_reg[0])
                count_reg <= (count_reg == 32'd0) ? load_reg : count_reg - 32'd1;

            if (wrap_set)
                wrap_reg <= 1'b1;
            else if (wr_intstat && PWDATA[0])
                wrap_reg <= 1'b0;
        end
    end

    assign count_val = count_reg;
    assign wrap_val  = wrap_reg;
    assign irq       = ctrl_reg[1] & wrap_reg;
`else
    assign count_val = 32'd0;
    assign wrap_val  = 1'b0;
    assign irq       = 1'b0;
`endif

    always_comb begin
        rd_mux = 32'd0;
        if (in_win) begin
            case (reg_idx)
                3'd0:    rd_mux = {30'd0, ctrl_reg};
                3'd1:    rd_mux = {30'd0, irq, ctrl_reg[0]};
                3'd2:    rd_mux = load_reg;
                3'd3:    rd_mux = count_val;
                3'd4:    rd_mux = {31'd0, wrap_val};
                3'd5:    rd_mux = scratch_reg;
                3'd6:    rd_mux = ID_VALUE;
                default: rd_mux = 32'd0;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            PRDATA <= 32'd0;
        else if (rd_capture)
            PRDATA <= rd_mux;
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Randomised bench for apb_reg_slave with a register-level reference model and read scoreboard.
// Timer checks are built only when APB_REG_TIMER_EN is defined, matching the DUT build.
`timescale 1ns/1ps
module tb_apb_reg_slave;

    localparam logic [31:0] BASE_ADDR   = 32'h0000_0000;
    localparam logic [31:0] LOAD_RST    = 32'h0000_FFFF;
    localparam logic [31:0] SCRATCH_RST = 32'h0000_0000;
    localparam logic [31:0] ID_VALUE    = 32'hA5B0_0001;

    logic        PCLK    = 1'b0;
    logic        PRESETn = 1'b1;
    logic        PSEL    = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE  = 1'b0;
    logic [31:0] PADDR   = 32'd0;
    logic [31:0] PWDATA  = 32'd0;
    logic [31:0] PRDATA;
    logic        irq;
    logic [1:0]  fsm_state;

    apb_reg_slave #(
        .BASE_ADDR  (BASE_ADDR),
        .LOAD_RST   (LOAD_RST),
        .SCRATCH_RST(SCRATCH_RST),
        .ID_VALUE   (ID_VALUE)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .irq      (irq),
        .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 PCLK = ~PCLK;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    // reference model state
    logic [1:0]  m_ctrl    = 2'b00;
    logic [31:0] m_load    = LOAD_RST;
    logic [31:0] m_scratch = SCRATCH_RST;
    logic [31:0] m_count   = 32'd0;
    logic        m_wrap    = 1'b0;
    logic        m_commit  = 1'b0;
    logic        m_cap     = 1'b0;
    logic        rd_chk    = 1'b0;
    logic [31:0] m_waddr   = 32'd0;
    logic [31:0] m_wdata   = 32'd0;
    logic [31:0] m_raddr   = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_index(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return (off < 32'd32) ? int'(off / 4) : -1;
    endfunction

    function automatic logic m_irq();
`ifdef APB_REG_TIMER_EN
        return m_ctrl[1] & m_wrap;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        case (m_index(a))
            0: return {30'd0, m_ctrl};
            1: return {30'd0, m_irq(), m_ctrl[0]};
            2: return m_load;
`ifdef APB_REG_TIMER_EN
            3: return m_count;
            4: return {31'd0, m_wrap};
`endif
            5: return m_scratch;
            6: return ID_VALUE;
            default: return 32'd0;
        endcase
    endfunction

    // model: one step per clock, from the register map rules
    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            m_ctrl    = 2'b00;
            m_load    = LOAD_RST;
            m_scratch = SCRATCH_RST;
            m_count   = 32'd0;
            m_wrap    = 1'b0;
        end else begin : step
            logic [31:0] nc;
            logic        nw;
            logic        en_old;
            logic        wrapped;
            if (m_cap)
                exp_q.push_back(model_read(m_raddr));
            en_old  = m_ctrl[0];
            nc      = m_count;
            nw      = m_wrap;
            wrapped = 1'b0;
`ifdef APB_REG_TIMER_EN
            if (en_old) begin
                if (m_count == 32'd0) begin
                    nc      = m_load;
                    nw      = 1'b1;
                    wrapped = 1'b1;
                end else begin
                    nc = m_count - 32'd1;
                end
            end
`endif
            if (m_commit) begin
                case (m_index(m_waddr))
                    0: begin
`ifdef APB_REG_TIMER_EN
                        if (!en_old && m_wdata[0])
                            nc = m_load;
`endif
                        m_ctrl = m_wdata[1:0];
                    end
                    2: m_load = m_wdata;
                    4: if (m_wdata[0] && !wrapped) nw = 1'b0;
                    5: m_scratch = m_wdata;
                    default: ;
                endcase
            end
            m_count = nc;
            m_wrap  = nw;
        end
    end

    // monitor: pops the scoreboard when read data is presented, checks irq every cycle
    always @(negedge PCLK) begin
        if (rd_chk) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL prdata: read presented with empty expected queue at %0t", $time);
            end else begin
                check("prdata", PRDATA, exp_q.pop_front());
            end
        end
        check("irq", {31'd0, irq}, {31'd0, m_irq()});
`ifdef APB_REG_TIMER_EN
        check("count_bd", dut.count_reg, m_count);
`endif
    end

    // driver tasks: each starts and ends 1ns after a rising edge
    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        m_commit = 1'b1; m_waddr = a; m_wdata = d;
        @(posedge PCLK); #1;
        m_commit = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        m_cap = 1'b1; m_raddr = a;
        @(posedge PCLK); #1;
        m_cap = 1'b0; PENABLE = 1'b1; rd_chk = 1'b1;
        @(posedge PCLK); #1;
        rd_chk = 1'b0;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic idle(input int n);
        PSEL = 1'b0; PENABLE = 1'b0;
        repeat (n) begin
            @(posedge PCLK); #1;
        end
    endtask

    logic [31:0] addr_tbl[10] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10,
                                  32'h14, 32'h18, 32'h1C, 32'h40, 32'h100};

    initial begin
        #1 PRESETn = 1'b0;
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1'b1;

        // reset values
        check("rst_prdata", PRDATA, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        apb_read(32'h18);
        apb_read(32'h08);
        apb_read(32'h00);
        apb_read(32'h14);
        idle(2);

        // scratch write then read back-to-back, plus back-door peek
        apb_write(32'h14, 32'hDEADBEEF);
        apb_read(32'h14);
        check("scratch_bd", dut.scratch_reg, 32'hDEADBEEF);
        apb_write(32'h08, 32'h0000_1234);
        apb_read(32'h08);
        idle(1);

`ifdef APB_REG_TIMER_EN
        // count sequence 3,2,1,0,3 with WRAP and irq on the reload edge
        apb_write(32'h08, 32'd3);
        apb_write(32'h00, 32'd3);
        for (int i = 0; i < 5; i++) begin
            logic [31:0] seq[5];
            seq = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd3};
            check("count_seq", dut.count_reg, seq[i]);
            if (i == 4) check("irq_on_wrap", {31'd0, irq}, 32'd1);
            @(posedge PCLK); #1;
        end
        apb_write(32'h00, 32'd2);
        check("irq_held", {31'd0, irq}, 32'd1);
        apb_write(32'h10, 32'd1);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        apb_read(32'h10);

        // LOAD=0: WRAP sets every cycle and wins over W1C
        apb_write(32'h08, 32'd0);
        apb_write(32'h00, 32'd3);
        repeat (4) begin
            apb_write(32'h10, 32'd1);
            check("wrap_set_wins", {31'd0, dut.wrap_reg}, 32'd1);
        end
        apb_read(32'h10);
        apb_write(32'h00, 32'd0);
        apb_write(32'h10, 32'd1);
        apb_read(32'h10);
        apb_read(32'h04);
`endif

        // reserved/unmapped writes ignored and read 0
        apb_write(32'h1C, 32'h0000_1234);
        apb_write(32'h40, 32'h0000_0055);
        apb_read(32'h1C);
        apb_read(32'h40);
        apb_write(32'h18, 32'hFFFF_FFFF);
        apb_read(32'h18);

        // PSEL&PENABLE straight from IDLE must not commit
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h14; PWDATA = 32'h0BAD_0BAD;
        repeat (2) begin
            @(posedge PCLK); #1;
        end
        idle(1);
        check("no_commit_bd", dut.scratch_reg, m_scratch);
        for (int i = 0; i < 8; i++) apb_read(32'(i * 4));

        // randomised traffic against the model
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            logic [31:0] d;
            a = addr_tbl[$urandom_range(0, 9)] | 32'($urandom_range(0, 3));
            d = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 12)) : $urandom;
            if ($urandom_range(0, 1) == 1)
                apb_write(a, d);
            else
                apb_read(a);
            if ($urandom_range(0, 3) == 0)
                idle($urandom_range(1, 3));
        end
        for (int i = 0; i < 8; i++) apb_read(32'(i * 4));

        // reset in the middle of a scratch write
        apb_write(32'h14, 32'hCAFE_F00D);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h14; PWDATA = 32'h1234_5678;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PRESETn = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        repeat (2) begin
            @(posedge PCLK); #1;
        end
        PRESETn = 1'b1;
        check("rst_mid_scratch_bd", dut.scratch_reg, SCRATCH_RST);
        check("rst_mid_prdata", PRDATA, 32'd0);
        apb_read(32'h14);
        apb_read(32'h00);
        idle(2);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
